sprite_pixel_gen: RTL



---
 rtl/sprite_pixel_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sprite_pixel_gen.sv
// Sprite pixel source for the RGB composer: 3-stage ROM-backed pixel pipeline plus
// frame-synchronous position/walk-animation control. Off-sprite pixels are always 12'h000.
module sprite_pixel_gen #(
  parameter int unsigned SPR_W    = 32,
  parameter int unsigned SPR_H    = 32,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned INIT_X   = 304,
  parameter int unsigned INIT_Y   = 224,
  parameter int unsigned STEP     = 2,
  parameter int unsigned ANIM_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid_in,
  input  logic        move_en,
  input  logic [1:0]  dir,
  output logic [10:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] pixel,
  output logic        valid_out,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y
);

  localparam int unsigned AnimW  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [10:0] MaxX   = 11'(SCREEN_W - SPR_W);
  localparam logic [10:0] MaxY   = 11'(SCREEN_H - SPR_H);
  localparam logic [10:0] Step11 = 11'(STEP);
  localparam logic [9:0]  Step10 = 10'(STEP);

  localparam logic [1:0] DirUp    = 2'd0;
  localparam logic [1:0] DirDown  = 2'd1;
  localparam logic [1:0] DirLeft  = 2'd2;
  localparam logic [1:0] DirRight = 2'd3;

  typedef enum logic [0:0] {StIdle, StArmed} state_e;

  state_e           state_q;
  logic [1:0]       dir_q;
  logic             pose_q;
  logic [AnimW-1:0] anim_cnt_q;
  logic             cond_q;
  logic             hit1_q, valid1_q, hit2_q, valid2_q;

  // Sprite hit test and ROM offset for the current scan position.
  logic       hit_x, hit_y, hit;
  logic [9:0] rel_x, rel_y, sprite_off;
  logic [10:0] x_end, y_end;

  assign x_end      = {1'b0, pos_x} + 11'(SPR_W);
  assign y_end      = {1'b0, pos_y} + 11'(SPR_H);
  assign hit_x      = (h_cnt >= pos_x) && ({1'b0, h_cnt} < x_end);
  assign hit_y      = (v_cnt >= pos_y) && ({1'b0, v_cnt} < y_end);
  assign hit        = hit_x && hit_y;
  assign rel_x      = h_cnt - pos_x;
  assign rel_y      = v_cnt - pos_y;
  assign sprite_off = 10'(rel_y * 10'(SPR_W) + rel_x);

  // One-clock frame tick at the first clk of the vblank marker position.
  logic cond, tick;
  assign cond = (h_cnt == 10'd0) && (v_cnt == 10'(SCREEN_H));
  assign tick = cond && !cond_q;

  // Saturating next position for the effective direction.
  logic [1:0]  mv_dir;
  logic        apply;
  logic [10:0] x_inc, y_inc;
  logic [9:0]  x_nxt, y_nxt;

  assign apply = (state_q == StArmed) || move_en;
  assign x_inc = {1'b0, pos_x} + Step11;
  assign y_inc = {1'b0, pos_y} + Step11;

  always_comb begin
    mv_dir = move_en ? dir : dir_q;
    x_nxt  = pos_x;
    y_nxt  = pos_y;
    unique case (mv_dir)
      DirUp:    y_nxt = (pos_y < Step10) ? 10'd0 : pos_y - Step10;
      DirDown:  y_nxt = (y_inc > MaxY) ? MaxY[9:0] : y_inc[9:0];
      DirLeft:  x_nxt = (pos_x < Step10) ? 10'd0 : pos_x - Step10;
      DirRight: x_nxt = (x_inc > MaxX) ? MaxX[9:0] : x_inc[9:0];
      default:  ;
    endcase
  end

  // Pixel pipeline: S1 address/hit, S2 ROM access, S3 gated output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit1_q    <= 1'b0;
      valid1_q  <= 1'b0;
      rom_addr  <= '0;
      hit2_q    <= 1'b0;
      valid2_q  <= 1'b0;
      pixel     <= '0;
      valid_out <= 1'b0;
      cond_q    <= 1'b0;
    end else begin
      hit1_q   <= hit;
      valid1_q <= valid_in;
      if (hit) begin
        rom_addr <= {pose_q, sprite_off};
      end
      hit2_q    <= hit1_q;
      valid2_q  <= valid1_q;
      pixel     <= (valid2_q && hit2_q) ? rom_data : 12'h000;
      valid_out <= valid2_q;
      cond_q    <= cond;
    end
  end

  // Move FSM, position and walk animation; everything visible changes only on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dir_q      <= 2'd0;
      pos_x      <= 10'(INIT_X);
      pos_y      <= 10'(INIT_Y);
      pose_q     <= 1'b0;
      anim_cnt_q <= '0;
    end else if (tick) begin
      state_q <= StIdle;
      if (apply) begin
        pos_x <= x_nxt;
        pos_y <= y_nxt;
        if (anim_cnt_q == AnimW'(ANIM_DIV - 1)) begin
          anim_cnt_q <= '0;
          pose_q     <= ~pose_q;
        end else begin
          anim_cnt_q <= anim_cnt_q + 1'b1;
        end
      end else begin
        anim_cnt_q <= '0;
        pose_q     <= 1'b0;
      end
    end else if (move_en) begin
      state_q <= StArmed;
      dir_q   <= dir;
    end
  end

endmodule
